// File: rtl/fb_packer_pkg.sv
// Constants and types shared by the LCD packer and the HDMI image generator.
// Both sides address the framebuffer as 48 word-rows of LCD_WIDTH 36-bit words.
package fb_packer_pkg;

   localparam int LCD_WIDTH    = 224;
   localparam int LCD_HEIGHT   = 144;
   localparam int PXL_PER_WORD = 3;
   localparam int FB_ADDR_W    = 14;

   typedef logic [11:0] rgb444_t;

   typedef enum logic {
      IDLE,
      ACTIVE
   } fbp_state_t;

endpackage

// File: rtl/fb_packer.sv
// Packs three vertically adjacent RGB444 LCD lines into one 36-bit framebuffer word via lane enables.
// Writes appear one cycle after the accepted pixel; no backpressure, the LCD stream is never stalled.
module fb_packer
   import fb_packer_pkg::*;
#(
   parameter int LINEWIDTH = LCD_WIDTH,
   parameter int LINES     = LCD_HEIGHT,
   parameter int ADDRW     = FB_ADDR_W
) (
   input  logic             pxlClk,
   input  logic             rst,
   input  logic [11:0]      lcdPxl,
   input  logic             lcdValid,
   input  logic             lcdLineStart,
   input  logic             lcdFrameStart,
   output logic [ADDRW-1:0] fbAddr,
   output logic [35:0]      fbData,
   output logic [2:0]       fbWe,
   output logic             frameDone,
   output logic             lineErr
);

   localparam logic [7:0]       C_XMAX      = 8'(LINEWIDTH);
   localparam logic [7:0]       C_LAST_X    = 8'(LINEWIDTH - 1);
   localparam logic [7:0]       C_LAST_LINE = 8'(LINES - 1);
   localparam logic [1:0]       C_LAST_LANE = 2'(PXL_PER_WORD - 1);
   localparam logic [ADDRW-1:0] C_ROW_STEP  = ADDRW'(LINEWIDTH);

   fbp_state_t       r_state, w_state;
   logic [7:0]       r_x, w_x, w_xe;
   logic [7:0]       r_line, w_line;
   logic [1:0]       r_lane, w_lane, w_lanee;
   logic [ADDRW-1:0] r_base, w_base, w_basee;
   logic [ADDRW-1:0] r_fbAddr, w_addr;
   logic [35:0]      r_fbData, w_data;
   logic [2:0]       r_fbWe, w_we;
   logic             r_frameDone, w_done;
   logic             r_donePend, w_pend;
   logic             r_lineErr, w_err;
   logic             w_live;

   always_ff @(posedge pxlClk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_line      <= '0;
         r_lane      <= '0;
         r_base      <= '0;
         r_fbAddr    <= '0;
         r_fbData    <= '0;
         r_fbWe      <= '0;
         r_frameDone <= 1'b0;
         r_donePend  <= 1'b0;
         r_lineErr   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_x         <= w_x;
         r_line      <= w_line;
         r_lane      <= w_lane;
         r_base      <= w_base;
         r_fbAddr    <= w_addr;
         r_fbData    <= w_data;
         r_fbWe      <= w_we;
         r_frameDone <= w_done | r_donePend;
         r_donePend  <= w_pend;
         r_lineErr   <= w_err;
      end
   end

   always_comb begin
      w_state = r_state;
      w_x     = r_x;
      w_line  = r_line;
      w_lane  = r_lane;
      w_base  = r_base;
      w_addr  = r_fbAddr;
      w_data  = r_fbData;
      w_we    = 3'b000;
      w_done  = 1'b0;
      w_pend  = 1'b0;
      w_err   = r_lineErr;
      w_xe    = r_x;
      w_lanee = r_lane;
      w_basee = r_base;
      w_live  = 1'b0;
      case (r_state)
         IDLE: begin
            if (lcdFrameStart) begin
               w_state = ACTIVE;
               w_x     = '0;
               w_line  = '0;
               w_lane  = '0;
               w_base  = '0;
               w_err   = 1'b0;
            end
         end
         ACTIVE: begin
            if (lcdFrameStart) begin
               w_x    = '0;
               w_line = '0;
               w_lane = '0;
               w_base = '0;
               w_err  = 1'b1;
            end else begin
               w_live = 1'b1;
               // A lineStart with x==0 is a duplicate marker and leaves the position alone.
               if (lcdLineStart && r_x != 8'd0) begin
                  if (r_x < C_XMAX) w_err = 1'b1;
                  if (r_line == C_LAST_LINE) begin
                     w_done  = 1'b1;
                     w_state = IDLE;
                     w_live  = 1'b0;
                  end else begin
                     w_xe   = '0;
                     w_line = r_line + 8'd1;
                     if (r_lane == C_LAST_LANE) begin
                        w_lanee = '0;
                        w_basee = r_base + C_ROW_STEP;
                     end else begin
                        w_lanee = r_lane + 2'd1;
                     end
                  end
               end
               w_x    = w_xe;
               w_lane = w_lanee;
               w_base = w_basee;
               if (w_live && lcdValid) begin
                  if (w_xe < C_XMAX) begin
                     w_addr = w_basee + ADDRW'(w_xe);
                     w_data = {lcdPxl, lcdPxl, lcdPxl};
                     w_we   = 3'b100 >> w_lanee;
                     w_x    = w_xe + 8'd1;
                     if (w_xe == C_LAST_X && w_line == C_LAST_LINE) begin
                        w_pend  = 1'b1;
                        w_state = IDLE;
                     end
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_comb begin
      fbAddr    = r_fbAddr;
      fbData    = r_fbData;
      fbWe      = r_fbWe;
      frameDone = r_frameDone;
      lineErr   = r_lineErr;
   end

endmodule

// File: tb/tb_fb_packer.sv
// Bench for fb_packer: vector table for short scenarios, scoreboard for full frames.
module tb_fb_packer;

   logic        pxlClk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] lcdPxl = '0;
   logic        lcdValid = 1'b0;
   logic        lcdLineStart = 1'b0;
   logic        lcdFrameStart = 1'b0;
   logic [13:0] fbAddr;
   logic [35:0] fbData;
   logic [2:0]  fbWe;
   logic        frameDone;
   logic        lineErr;

   fb_packer dut (
      .pxlClk        (pxlClk),
      .rst           (rst),
      .lcdPxl        (lcdPxl),
      .lcdValid      (lcdValid),
      .lcdLineStart  (lcdLineStart),
      .lcdFrameStart (lcdFrameStart),
      .fbAddr        (fbAddr),
      .fbData        (fbData),
      .fbWe          (fbWe),
      .frameDone     (frameDone),
      .lineErr       (lineErr)
   );

   always #5 pxlClk = ~pxlClk;

   typedef struct packed {
      logic [13:0] addr;
      logic [2:0]  we;
      logic [35:0] data;
   } wr_t;

   typedef struct {
      bit          rst;
      bit          fs;
      bit          ls;
      int          npix;
      logic [11:0] pxl;
      logic [13:0] addr;
      logic [2:0]  we;
      bit          err;
      int          wr;
   } vec_t;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          last_wr_cyc = 0;
   int          done_cyc = 0;
   bit          sb_on = 1'b0;
   wr_t         exp_q[$];
   logic [35:0] fb_mem [0:10751];
   vec_t        vecs [10];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic monitor_loop();
      wr_t e;
      forever begin
         @(negedge pxlClk);
         cyc++;
         if (fbWe != 3'b000) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (int'(fbAddr) < 10752) begin
               if (fbWe[2]) fb_mem[fbAddr][35:24] = fbData[35:24];
               if (fbWe[1]) fb_mem[fbAddr][23:12] = fbData[23:12];
               if (fbWe[0]) fb_mem[fbAddr][11:0]  = fbData[11:0];
            end
            if (sb_on) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_unexpected_write: got addr %0d we %b, expected no write", fbAddr, fbWe);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_write", 64'({fbAddr, fbWe, fbData}), 64'(e));
               end
            end
         end
         if (frameDone) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   endtask

   task automatic step(bit r, bit f, bit l, bit v, logic [11:0] p);
      rst = r; lcdFrameStart = f; lcdLineStart = l; lcdValid = v; lcdPxl = p;
      @(posedge pxlClk);
      #1;
      rst = 1'b0; lcdFrameStart = 1'b0; lcdLineStart = 1'b0; lcdValid = 1'b0;
   endtask

   task automatic settle();
      @(negedge pxlClk);
      #1;
   endtask

   task automatic pix(int ln, int x);
      logic [11:0] p;
      wr_t e;
      p = 12'(ln * 16 + (x % 16));
      if (sb_on && x < 224) begin
         e.addr = 14'((ln / 3) * 224 + x);
         e.we   = 3'b100 >> (ln % 3);
         e.data = {p, p, p};
         exp_q.push_back(e);
      end
      step(0, 0, 0, 1, p);
   endtask

   task automatic run_line(int ln, int n);
      step(0, 0, 1, 0, 12'h000);
      for (int x = 0; x < n; x++) pix(ln, x);
   endtask

   task automatic run_frame();
      step(0, 1, 0, 0, 12'h000);
      for (int l = 0; l < 144; l++) run_line(l, 224);
      repeat (4) step(0, 0, 0, 0, 12'h000);
      settle();
   endtask

   initial begin
      int w0, d0;
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] c;
      fork
         monitor_loop();
      join_none

      // {rst, fs, ls, npix, pxl, addr, we, err, writes}
      vecs[0] = '{1, 1, 1,   6, 12'h005, 14'd5,   3'b100, 0,   6};
      vecs[1] = '{0, 0, 1,   6, 12'h015, 14'd5,   3'b010, 1,   6};
      vecs[2] = '{0, 0, 1,   6, 12'h025, 14'd5,   3'b001, 1,   6};
      vecs[3] = '{0, 0, 1,   6, 12'h035, 14'd229, 3'b100, 1,   6};
      vecs[4] = '{1, 1, 1, 224, 12'hA0A, 14'd223, 3'b100, 0, 224};
      vecs[5] = '{0, 0, 1, 224, 12'hB0B, 14'd223, 3'b010, 0, 224};
      vecs[6] = '{0, 0, 1, 100, 12'hC0C, 14'd99,  3'b001, 0, 100};
      vecs[7] = '{0, 0, 1,   1, 12'h123, 14'd224, 3'b100, 1,   1};
      vecs[8] = '{1, 1, 1, 230, 12'h777, 14'd223, 3'b000, 1, 224};
      vecs[9] = '{0, 0, 1,   1, 12'h456, 14'd0,   3'b010, 1,   1};

      repeat (3) step(1, 0, 0, 0, 12'h000);
      settle();
      chk("rst_addr", 64'(fbAddr), 64'd0);
      chk("rst_data", 64'(fbData), 64'd0);
      chk("rst_we", 64'(fbWe), 64'd0);
      chk("rst_done", 64'(frameDone), 64'd0);
      chk("rst_err", 64'(lineErr), 64'd0);

      w0 = wr_cnt;
      for (int i = 0; i < 12; i++) step(0, 0, (i % 4) == 0, i[0], 12'hFFF);
      settle();
      chk("idle_no_writes", 64'(wr_cnt - w0), 64'd0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].rst) step(1, 0, 0, 0, 12'h000);
         if (vecs[i].fs) step(0, 1, 0, 0, 12'h000);
         w0 = wr_cnt;
         if (vecs[i].ls) step(0, 0, 1, 0, 12'h000);
         for (int n = 0; n < vecs[i].npix; n++) step(0, 0, 0, 1, vecs[i].pxl);
         settle();
         chk($sformatf("vec%0d_addr", i), 64'(fbAddr), 64'(vecs[i].addr));
         chk($sformatf("vec%0d_we", i), 64'(fbWe), 64'(vecs[i].we));
         chk($sformatf("vec%0d_data", i), 64'(fbData), 64'({vecs[i].pxl, vecs[i].pxl, vecs[i].pxl}));
         chk($sformatf("vec%0d_err", i), 64'(lineErr), 64'(vecs[i].err));
         chk($sformatf("vec%0d_writes", i), 64'(wr_cnt - w0), 64'(vecs[i].wr));
      end

      // Reset in the middle of a line, with lineErr previously set.
      step(1, 0, 0, 0, 12'h000);
      step(0, 1, 0, 0, 12'h000);
      step(0, 1, 0, 0, 12'h000);
      step(0, 0, 1, 0, 12'h000);
      for (int n = 0; n < 50; n++) step(0, 0, 0, 1, 12'h3C3);
      settle();
      chk("pre_rst_err", 64'(lineErr), 64'd1);
      d0 = done_cnt;
      step(1, 0, 0, 1, 12'h3C3);
      settle();
      chk("midrst_we", 64'(fbWe), 64'd0);
      chk("midrst_done", 64'(frameDone), 64'd0);
      chk("midrst_err", 64'(lineErr), 64'd0);
      w0 = wr_cnt;
      for (int n = 0; n < 8; n++) step(0, 0, 0, 1, 12'h3C3);
      settle();
      chk("after_rst_idle_writes", 64'(wr_cnt - w0), 64'd0);
      chk("after_rst_no_done", 64'(done_cnt - d0), 64'd0);

      // Full clean frame through the scoreboard.
      step(1, 0, 0, 0, 12'h000);
      sb_on = 1'b1;
      w0 = wr_cnt;
      d0 = done_cnt;
      run_frame();
      a = 12'h8DF; b = 12'h8EF; c = 12'h8FF;
      chk("frame_word_10751", 64'(fb_mem[10751]), 64'({a, b, c}));
      chk("frame_writes", 64'(wr_cnt - w0), 64'd32256);
      chk("frame_done_count", 64'(done_cnt - d0), 64'd1);
      chk("frame_done_timing", 64'(done_cyc - last_wr_cyc), 64'd1);
      chk("frame_err", 64'(lineErr), 64'd0);
      chk("frame_sb_empty", 64'(exp_q.size()), 64'd0);

      // Restart during line 50, then a complete frame.
      step(1, 0, 0, 0, 12'h000);
      d0 = done_cnt;
      step(0, 1, 0, 0, 12'h000);
      for (int l = 0; l < 50; l++) run_line(l, 224);
      run_line(50, 10);
      settle();
      chk("restart_pre_err", 64'(lineErr), 64'd0);
      w0 = wr_cnt;
      run_frame();
      chk("restart_err_sticky", 64'(lineErr), 64'd1);
      chk("restart_writes", 64'(wr_cnt - w0), 64'd32256);
      chk("restart_done_count", 64'(done_cnt - d0), 64'd1);
      chk("restart_done_timing", 64'(done_cyc - last_wr_cyc), 64'd1);
      chk("restart_sb_empty", 64'(exp_q.size()), 64'd0);
      sb_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
